// File: rtl/reset_conditioner.sv
// -----------------------------------------------------------------------------
// reset_conditioner
//
// Front-end reset source for the system controller. Merges the board power-on
// reset, a bouncing pushbutton and an optional software reset request into one
// clean, synchronous, active-high reset pulse of guaranteed minimum width.
// reset_cause_o records which source fired last so firmware can read it after
// boot.
//
// Optional feature macro: RESET_CONDITIONER_SW_RESET_EN
//   defined     -> sw_reset_i starts a pulse from IDLE or DEBOUNCE (cause 10)
//   not defined -> sw_reset_i is present but ignored; cause 10 never appears
//
// Parameters:
//   SYNC_STAGES      flops in the button and reset-release synchronizers (>= 2)
//   DEBOUNCE_CYCLES  cycles of stable level to accept a press or a release
//   PULSE_CYCLES     width of every reset_o pulse, in cycles
//   CNT_W            counter width, must hold max(DEBOUNCE, PULSE) - 1
//
// Ports:
//   clk_i          in   board clock, the only clock
//   reset_i        in   power-on reset, asynchronous, active-low
//   button_i       in   raw pushbutton, asynchronous, high = pressed
//   sw_reset_i     in   software reset request, single-cycle, clk_i domain
//   reset_o        out  conditioned reset, active-high, registered
//   reset_cause_o  out  last cause: 00 POR, 01 button, 10 software
//   busy_o         out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module reset_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_CYCLES    = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       button_i,
  input  logic       sw_reset_i,
  output logic       reset_o,
  output logic [1:0] reset_cause_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    ST_POR          = 3'd0,
    ST_IDLE         = 3'd1,
    ST_DEBOUNCE     = 3'd2,
    ST_PULSE        = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR    = 2'b00,
    CAUSE_BUTTON = 2'b01,
    CAUSE_SW     = 2'b10
  } cause_e;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  // ---------------------------------------------------------------------------
  // Reset-release synchronizer: assertion is immediate, release is aligned to
  // clk_i after SYNC_STAGES edges so the FSM never leaves reset mid-cycle.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] rst_sync;
  logic                   rst_sync_n;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Button synchronizer; button_i is sampled nowhere else.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] btn_meta;
  logic                   btn_sync;

  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      btn_meta <= '0;
    end else begin
      btn_meta <= {btn_meta[SYNC_STAGES-2:0], button_i};
    end
  end

  assign btn_sync = btn_meta[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Software request qualification
  // ---------------------------------------------------------------------------
  logic sw_req;

`ifdef RESET_CONDITIONER_SW_RESET_EN
  assign sw_req = sw_reset_i;
`else
  logic unused_sw_reset;
  assign sw_req          = 1'b0;
  assign unused_sw_reset = sw_reset_i;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  state_e           state, state_n;
  cause_e           cause, cause_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;

  // Saturating increment: a stuck condition can never wrap the counter back
  // into a range that matches a terminal count.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    cause_n = cause;
    cnt_n   = cnt_inc;

    case (state)
      ST_POR: begin
        if (cnt == PULSE_LAST) begin
          state_n = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (sw_req) begin
          state_n = ST_PULSE;
          cause_n = CAUSE_SW;
        end else if (btn_sync) begin
          state_n = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        // A software request pre-empts a press still being qualified.
        if (sw_req) begin
          state_n = ST_PULSE;
          cause_n = CAUSE_SW;
        end else if (!btn_sync) begin
          state_n = ST_IDLE;
        end else if (cnt == DEB_LAST) begin
          state_n = ST_PULSE;
          cause_n = CAUSE_BUTTON;
        end
      end

      ST_PULSE: begin
        // Only a button pulse must wait for the button to be let go, otherwise
        // a held button would re-trigger straight away.
        if (cnt == PULSE_LAST) begin
          state_n = (cause == CAUSE_BUTTON) ? ST_RELEASE_WAIT : ST_IDLE;
        end
      end

      ST_RELEASE_WAIT: begin
        if (btn_sync) begin
          cnt_n = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_POR;
      end
    endcase

    // One counter serves every state; it restarts on each state entry.
    if (state_n != state) begin
      cnt_n = '0;
    end
  end

  // Outputs are registered decodes of the next state, so reset_o rises on the
  // same edge that enters PULSE and has no combinational glitches.
  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state   <= ST_POR;
      cause   <= CAUSE_POR;
      cnt     <= '0;
      reset_o <= 1'b1;
      busy_o  <= 1'b1;
    end else begin
      state   <= state_n;
      cause   <= cause_n;
      cnt     <= cnt_n;
      reset_o <= (state_n == ST_POR) || (state_n == ST_PULSE);
      busy_o  <= (state_n != ST_IDLE);
    end
  end

  assign reset_cause_o = cause;

endmodule

// File: tb/tb_reset_conditioner.sv
// -----------------------------------------------------------------------------
// tb_reset_conditioner
//
// Directed bench for reset_conditioner with DEBOUNCE_CYCLES = 8,
// PULSE_CYCLES = 4, SYNC_STAGES = 2. A table of {inputs, cycle count,
// expected outputs} rows is applied one clock at a time; inputs change on the
// falling edge and outputs are compared on the following falling edge. A few
// hand-written sequences then measure latency, pulse width, release timing and
// the asynchronous reset path. Expectations follow RESET_CONDITIONER_SW_RESET_EN.
// -----------------------------------------------------------------------------
module tb_reset_conditioner;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int PULSE_CYCLES    = 4;
  localparam int CNT_W           = 16;

`ifdef RESET_CONDITIONER_SW_RESET_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  // Cause left behind by the software-reset rows: 10 when honoured, else the
  // button cause from the preceding press stays in place.
  localparam logic [1:0] PC = SW_EN ? 2'b10 : 2'b01;

  logic       clk_i      = 1'b0;
  logic       reset_i    = 1'b1;
  logic       button_i   = 1'b0;
  logic       sw_reset_i = 1'b0;
  logic       reset_o;
  logic [1:0] reset_cause_o;
  logic       busy_o;

  reset_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .PULSE_CYCLES   (PULSE_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .button_i     (button_i),
    .sw_reset_i   (sw_reset_i),
    .reset_o      (reset_o),
    .reset_cause_o(reset_cause_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic       btn;
    logic       sw;
    int         n;
    logic       exp_reset;
    logic       exp_busy;
    logic [1:0] exp_cause;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic btn, input logic sw, input int n,
                     input logic er, input logic eb, input logic [1:0] ec);
    vec_t v;
    v.rst       = rst;
    v.btn       = btn;
    v.sw        = sw;
    v.n         = n;
    v.exp_reset = er;
    v.exp_busy  = eb;
    v.exp_cause = ec;
    vecs.push_back(v);
  endtask

  function automatic int pack_out(input logic r, input logic b, input logic [1:0] c);
    return int'({r, b, c});
  endfunction

  initial begin
    int lat;
    int width;
    int rel;

    // ---- power-on reset: low 3 cycles, then 2 sync + 4 POR cycles high ----
    add(0, 0, 0, 3, 1, 1, 2'b00);
    add(1, 0, 0, 5, 1, 1, 2'b00);
    add(1, 0, 0, 3, 0, 0, 2'b00);

    // ---- bounce: high 5, low 3, high 5, low -> two rejected DEBOUNCE visits
    add(1, 1, 0, 2, 0, 0, 2'b00);
    add(1, 1, 0, 3, 0, 1, 2'b00);
    add(1, 0, 0, 2, 0, 1, 2'b00);
    add(1, 0, 0, 1, 0, 0, 2'b00);
    add(1, 1, 0, 2, 0, 0, 2'b00);
    add(1, 1, 0, 3, 0, 1, 2'b00);
    add(1, 0, 0, 2, 0, 1, 2'b00);
    add(1, 0, 0, 3, 0, 0, 2'b00);

    // ---- valid press held 40 cycles: one 4-cycle pulse, then release wait --
    add(1, 1, 0,  2, 0, 0, 2'b00);
    add(1, 1, 0,  8, 0, 1, 2'b00);
    add(1, 1, 0,  4, 1, 1, 2'b01);
    add(1, 1, 0, 26, 0, 1, 2'b01);
    add(1, 0, 0,  9, 0, 1, 2'b01);
    add(1, 0, 0,  3, 0, 0, 2'b01);

    // ---- software request in IDLE, second request inside PULSE ------------
    if (SW_EN) begin
      add(1, 0, 1, 1, 1, 1, 2'b10);
      add(1, 0, 0, 1, 1, 1, 2'b10);
      add(1, 0, 1, 1, 1, 1, 2'b10);
      add(1, 0, 0, 1, 1, 1, 2'b10);
      add(1, 0, 0, 3, 0, 0, 2'b10);
    end else begin
      add(1, 0, 1, 1, 0, 0, 2'b01);
      add(1, 0, 0, 1, 0, 0, 2'b01);
      add(1, 0, 1, 1, 0, 0, 2'b01);
      add(1, 0, 0, 4, 0, 0, 2'b01);
    end

    // ---- software request during DEBOUNCE (button held 10 cycles) ---------
    if (SW_EN) begin
      add(1, 1, 0, 2, 0, 0, PC);
      add(1, 1, 0, 2, 0, 1, PC);
      add(1, 1, 1, 1, 1, 1, 2'b10);
      add(1, 1, 0, 3, 1, 1, 2'b10);
      add(1, 1, 0, 1, 0, 0, 2'b10);  // back in IDLE, not RELEASE_WAIT
      add(1, 1, 0, 1, 0, 1, 2'b10);  // still-high button re-enters DEBOUNCE
      add(1, 0, 0, 2, 0, 1, 2'b10);
      add(1, 0, 0, 3, 0, 0, 2'b10);
    end else begin
      add(1, 1, 0, 2, 0, 0, PC);
      add(1, 1, 0, 2, 0, 1, PC);
      add(1, 1, 1, 1, 0, 1, PC);
      add(1, 1, 0, 5, 0, 1, PC);
      add(1, 0, 0, 4, 1, 1, 2'b01);
      add(1, 0, 0, 8, 0, 1, 2'b01);
      add(1, 0, 0, 3, 0, 0, 2'b01);
    end

    // ---- reset_i low for one cycle on the 2nd PULSE cycle -----------------
    add(1, 1, 0, 2, 0, 0, PC);
    add(1, 1, 0, 8, 0, 1, PC);
    add(1, 1, 0, 2, 1, 1, 2'b01);
    add(0, 0, 0, 1, 1, 1, 2'b00);
    add(1, 0, 0, 5, 1, 1, 2'b00);
    add(1, 0, 0, 3, 0, 0, 2'b00);

    #2;
    foreach (vecs[r]) begin
      for (int c = 0; c < vecs[r].n; c++) begin
        reset_i    = vecs[r].rst;
        button_i   = vecs[r].btn;
        sw_reset_i = vecs[r].sw;
        @(negedge clk_i);
        check($sformatf("row%0d.cyc%0d {reset,busy,cause}", r, c),
              pack_out(reset_o, busy_o, reset_cause_o),
              pack_out(vecs[r].exp_reset, vecs[r].exp_busy, vecs[r].exp_cause));
      end
    end

    // ---- press latency, pulse width and release timing --------------------
    button_i = 1'b1;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk_i);
      if (reset_o) begin
        lat = i;
        break;
      end
    end
    check("press_to_reset_edges", lat, SYNC_STAGES + DEBOUNCE_CYCLES + 1);

    width = 0;
    for (int i = 0; i < 20 && reset_o; i++) begin
      width++;
      @(negedge clk_i);
    end
    check("button_pulse_width", width, PULSE_CYCLES);
    check("button_pulse_cause", int'(reset_cause_o), 1);
    check("busy_held_while_pressed", int'(busy_o), 1);

    button_i = 1'b0;
    rel = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin
        rel = i;
        break;
      end
    end
    check("release_to_idle_edges", rel, SYNC_STAGES + DEBOUNCE_CYCLES);

    // ---- asynchronous reset between clock edges ---------------------------
    @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    #1;
    check("async_reset_forces_outputs", pack_out(reset_o, busy_o, reset_cause_o),
          pack_out(1'b1, 1'b1, 2'b00));

    @(negedge clk_i);
    reset_i = 1'b1;
    rel = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk_i);
      if (!reset_o) begin
        rel = i;
        break;
      end
    end
    check("por_release_edges", rel, SYNC_STAGES + PULSE_CYCLES);
    check("por_idle_outputs", pack_out(reset_o, busy_o, reset_cause_o),
          pack_out(1'b0, 1'b0, 2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
